// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the memory bus responder.
package mem_bus_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;

  // 6502 convention on rw
  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

endpackage

// File: rtl/wait_state_counter.sv
// 4-bit loadable down-counter that flags zero; it stops at zero rather than wrapping.
module wait_state_counter (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_load,
  input  logic [3:0] i_load_val,
  input  logic       i_dec,
  output logic       o_zero
);

  logic [3:0] r_count;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_count <= 4'd0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != 4'd0)) begin
      r_count <= r_count - 4'd1;
    end
  end

  assign o_zero = (r_count == 4'd0);

endmodule

// File: rtl/memory_bus_responder.sv
// Byte-wide memory responder with programmable wait states and address mirroring.
// Define MEM_WRITE_PROTECT_EN to block writes at or above ROM_BASE and pulse wp_err.
module memory_bus_responder
  import mem_bus_pkg::*;
#(
  parameter int unsigned       WAIT_STATES    = 1,
  parameter int unsigned       MEM_DEPTH_LOG2 = 12,
  parameter logic [ADDR_W-1:0] ROM_BASE       = 16'hF000
) (
  input  logic              FSM_Signal,
  input  logic              reset_MEM_n,
  input  logic [ADDR_W-1:0] ADDR_IN,
  input  logic              req,
  input  logic              rw,
  input  logic [DATA_W-1:0] DATA_IN,
  output logic [DATA_W-1:0] DATA_OUT,
  output logic              ready,
  output logic              busy,
  output logic              wp_err
);

  localparam int unsigned MemWords = 1 << MEM_DEPTH_LOG2;
  localparam logic [3:0]  WaitLoad = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t                    r_state, w_state_d;
  logic [ADDR_W-1:0]         r_addr;
  logic                      r_rw;
  logic [DATA_W-1:0]         r_data;
  logic [DATA_W-1:0]         r_data_out;
  logic [DATA_W-1:0]         r_mem [0:MemWords-1];
  logic                      w_load, w_dec, w_cnt_zero;
  logic                      w_accept;
  logic                      w_acc_rw;
  logic [MEM_DEPTH_LOG2-1:0] w_acc_idx;
  logic                      w_wp_block;

  wait_state_counter u_wait_cnt (
    .i_clk      (FSM_Signal),
    .i_rst_n    (reset_MEM_n),
    .i_load     (w_load),
    .i_load_val (WaitLoad),
    .i_dec      (w_dec),
    .o_zero     (w_cnt_zero)
  );

  assign w_accept = (r_state == IDLE) && req;

  always_comb begin
    w_state_d = r_state;
    w_load    = 1'b0;
    w_dec     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (req) begin
          if (WAIT_STATES > 0) begin
            w_state_d = WAIT;
            w_load    = 1'b1;
          end else begin
            w_state_d = ACK;
          end
        end
      end
      WAIT: begin
        w_dec = 1'b1;
        if (w_cnt_zero) w_state_d = ACK;
      end
      ACK:     w_state_d = IDLE;
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge FSM_Signal) begin
    if (!reset_MEM_n) r_state <= IDLE;
    else              r_state <= w_state_d;
  end

  always_ff @(posedge FSM_Signal) begin
    if (w_accept) begin
      r_addr <= ADDR_IN;
      r_rw   <= rw;
      r_data <= DATA_IN;
    end
  end

  // Read data is captured on entry to ACK so it is valid alongside ready; with zero
  // wait states that entry happens straight from IDLE, before the latches are loaded.
  assign w_acc_rw  = (r_state == IDLE) ? rw : r_rw;
  assign w_acc_idx = (r_state == IDLE) ? ADDR_IN[MEM_DEPTH_LOG2-1:0]
                                       : r_addr[MEM_DEPTH_LOG2-1:0];

  always_ff @(posedge FSM_Signal) begin
    if (!reset_MEM_n) begin
      r_data_out <= '0;
    end else if ((w_state_d == ACK) && (r_state != ACK) && (w_acc_rw == RW_READ)) begin
      r_data_out <= r_mem[w_acc_idx];
    end
  end

`ifdef MEM_WRITE_PROTECT_EN
  assign w_wp_block = (r_addr >= ROM_BASE);
`else
  logic w_unused_rom;
  assign w_wp_block   = 1'b0;
  assign w_unused_rom = ^{ROM_BASE, r_addr};
`endif

  // Storage has no reset; a reset during ACK suppresses the pending write.
  always_ff @(posedge FSM_Signal) begin
    if (reset_MEM_n && (r_state == ACK) && (r_rw == RW_WRITE) && !w_wp_block) begin
      r_mem[r_addr[MEM_DEPTH_LOG2-1:0]] <= r_data;
    end
  end

  assign DATA_OUT = r_data_out;
  assign ready    = (r_state == ACK);
  assign busy     = (r_state != IDLE);
  assign wp_err   = (r_state == ACK) && (r_rw == RW_WRITE) && w_wp_block;

endmodule
